// File: rtl/fifo_wr_arb.sv
`default_nettype none
//------------------------------------------------------------------------------
// fifo_wr_arb : round-robin burst arbiter sharing one FIFO write port among NREQ
// producers. Define FIFO_WR_ARB_PRIO_EN to give producer 0 priority.  Rev 1.0
//------------------------------------------------------------------------------
module fifo_wr_arb #(
  parameter int NREQ       = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [NREQ-1:0]              req,
  input  logic [NREQ*DATA_WIDTH-1:0]   din,
  input  logic                         full,
  output logic                         wr,
  output logic [DATA_WIDTH-1:0]        w_data,
  output logic [NREQ-1:0]              gnt,
  output logic                         busy,
  output logic [$clog2(NREQ)-1:0]      owner
);

  localparam int OW = $clog2(NREQ);
  localparam int BW = $clog2(MAX_BURST + 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t                  state_q;
  logic [OW-1:0]           owner_q;
  logic [OW-1:0]           last_q;
  logic [BW-1:0]           beats_q;
  logic                    req_own;
  logic                    burst_end;
  logic [DATA_WIDTH-1:0]   slice [NREQ];

  // Search from+1, from+2, ... wrapping; 'from' itself is examined last.
  function automatic logic [OW-1:0] pick(input logic [NREQ-1:0] vec,
                                         input logic [OW-1:0]   from);
    logic [OW-1:0] res;
    logic [OW-1:0] idx;
    logic          found;
    res   = from;
    found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = OW'((int'(from) + k) % NREQ);
      if (!found && vec[idx]) begin
        res   = idx;
        found = 1'b1;
      end
    end
    return res;
  endfunction

  function automatic logic [OW-1:0] arb_pick(input logic [NREQ-1:0] vec,
                                             input logic [OW-1:0]   from);
`ifdef FIFO_WR_ARB_PRIO_EN
    logic [NREQ-1:0] others;
    others    = vec;
    others[0] = 1'b0;
    if (vec[0]) return '0;
    return pick(others, from);
`else
    return pick(vec, from);
`endif
  endfunction

  for (genvar i = 0; i < NREQ; i++) begin : g_slice
    assign slice[i] = din[i*DATA_WIDTH +: DATA_WIDTH];
  end

  always_comb begin
    req_own   = req[owner_q];
    wr        = (state_q == BURST) && req_own && !full;
    gnt       = '0;
    gnt[owner_q] = wr;
    // full alone never terminates a burst; only a final beat or a dropped req does.
    burst_end = (wr && (beats_q == BW'(MAX_BURST - 1))) || !req_own;
  end

  assign w_data = slice[owner_q];
  assign busy   = (state_q == BURST);
  assign owner  = owner_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      owner_q <= '0;
      beats_q <= '0;
      last_q  <= OW'(NREQ - 1);
    end else begin
      case (state_q)
        IDLE: begin
          if (|req) begin
            owner_q <= arb_pick(req, last_q);
            beats_q <= '0;
            state_q <= BURST;
          end
        end
        BURST: begin
          if (wr) beats_q <= beats_q + BW'(1);
          if (burst_end) begin
            last_q <= owner_q;
            if (|req) begin
              owner_q <= arb_pick(req, owner_q);
              beats_q <= '0;
            end else begin
              state_q <= IDLE;
            end
          end
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arb.sv
`default_nettype none
// Scoreboard bench for fifo_wr_arb: directed scenarios then randomized traffic
// checked cycle by cycle against a behavioural arbitration model.
module tb_fifo_wr_arb;
  localparam int NREQ = 4;
  localparam int DW   = 8;
  localparam int MAXB = 4;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [NREQ-1:0]   req;
  logic [NREQ*DW-1:0] din;
  logic              full;
  logic              wr;
  logic [DW-1:0]     w_data;
  logic [NREQ-1:0]   gnt;
  logic              busy;
  logic [1:0]        owner;

  fifo_wr_arb #(.NREQ(NREQ), .DATA_WIDTH(DW), .MAX_BURST(MAXB)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .din(din), .full(full),
    .wr(wr), .w_data(w_data), .gnt(gnt), .busy(busy), .owner(owner)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    bit          wr;
    logic [3:0]  gnt;
    bit          busy;
    int          owner;
    logic [7:0]  data;
  } rec_t;

  rec_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;

  // Behavioural model: who holds the port and how many beats it may still write.
  bit         m_busy;
  int         m_owner;
  int         m_left;
  int         m_last;
  bit         in_rst;
  logic [7:0] pdata [NREQ];

  function automatic int rr_pick(input logic [3:0] v, input int from);
    for (int k = 1; k <= NREQ; k++)
      if (v[(from + k) % NREQ]) return (from + k) % NREQ;
    return from;
  endfunction

  function automatic int arb(input logic [3:0] v, input int from);
    logic [3:0] o;
    o = v;
`ifdef FIFO_WR_ARB_PRIO_EN
    if (v[0]) return 0;
    o[0] = 1'b0;
`endif
    return rr_pick(o, from);
  endfunction

  task automatic model_reset();
    m_busy  = 0;
    m_owner = 0;
    m_left  = 0;
    m_last  = NREQ - 1;
  endtask

  // Applies the clock edge just taken, using the inputs that were present before it.
  task automatic model_edge();
    bit w;
    if (in_rst) return;
    if (!m_busy) begin
      if (|req) begin
        m_owner = arb(req, m_last);
        m_left  = MAXB;
        m_busy  = 1;
      end
    end else begin
      w = req[m_owner] && !full;
      if (w) begin
        m_left--;
        pdata[m_owner] = 8'($urandom);
      end
      if ((w && m_left == 0) || !req[m_owner]) begin
        m_last = m_owner;
        if (|req) begin
          m_owner = arb(req, m_owner);
          m_left  = MAXB;
        end else begin
          m_busy = 0;
        end
      end
    end
  endtask

  task automatic drive_din();
    din = {pdata[3], pdata[2], pdata[1], pdata[0]};
  endtask

  task automatic push_expect();
    rec_t e;
    e.cyc   = cyc;
    e.wr    = m_busy && req[m_owner] && !full;
    e.gnt   = e.wr ? (4'b0001 << m_owner) : 4'b0000;
    e.busy  = m_busy;
    e.owner = m_owner;
    e.data  = pdata[m_owner];
    exp_q.push_back(e);
  endtask

  task automatic cycle(input logic [3:0] r, input logic f);
    @(posedge clk);
    cyc++;
    #1;
    model_edge();
    req  = r;
    full = f;
    drive_din();
    push_expect();
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Asserts reset partway through a cycle and verifies outputs clear without an edge.
  task automatic reset_mid(input logic [3:0] r);
    @(posedge clk);
    cyc++;
    #1;
    model_edge();
    req  = r;
    full = 1'b0;
    drive_din();
    reset_n = 1'b0;
    in_rst  = 1;
    #1;
    chk("async_rst_wr",    8'(wr),    8'h00);
    chk("async_rst_gnt",   8'(gnt),   8'h00);
    chk("async_rst_busy",  8'(busy),  8'h00);
    chk("async_rst_owner", 8'(owner), 8'h00);
    model_reset();
    push_expect();
  endtask

  always @(negedge clk) begin
    rec_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (e.cyc != cyc || wr !== e.wr || gnt !== e.gnt || busy !== e.busy ||
          owner !== 2'(e.owner) || w_data !== e.data) begin
        errors++;
        $display("FAIL cycle%0d: got wr=%b gnt=%b busy=%b owner=%0d w_data=%h expected wr=%b gnt=%b busy=%b owner=%0d w_data=%h (rec cyc %0d)",
                 cyc, wr, gnt, busy, owner, w_data, e.wr, e.gnt, e.busy, e.owner, e.data, e.cyc);
      end
    end
  end

  initial begin
    logic [3:0] r;
    logic       f;
    reset_n = 1'b0;
    in_rst  = 1;
    req     = '0;
    full    = 1'b0;
    for (int i = 0; i < NREQ; i++) pdata[i] = 8'($urandom);
    drive_din();
    model_reset();
    #3;
    chk("reset_wr",    8'(wr),     8'h00);
    chk("reset_gnt",   8'(gnt),    8'h00);
    chk("reset_busy",  8'(busy),   8'h00);
    chk("reset_owner", 8'(owner),  8'h00);
    chk("reset_wdata", w_data,     pdata[0]);
    repeat (2) cycle(4'b0000, 1'b0);
    reset_n = 1'b1;
    in_rst  = 0;

    // single producer, six beats
    repeat (7) cycle(4'b0100, 1'b0);
    repeat (2) cycle(4'b0000, 1'b0);
    // fairness among 0,1,3
    repeat (26) cycle(4'b1011, 1'b0);
    repeat (2) cycle(4'b0000, 1'b0);
    // backpressure on producer 1 after its second beat
    repeat (3) cycle(4'b0010, 1'b0);
    repeat (3) cycle(4'b0010, 1'b1);
    repeat (3) cycle(4'b0010, 1'b0);
    repeat (2) cycle(4'b0000, 1'b0);
    // early release of producer 2 with producer 3 waiting
    repeat (3) cycle(4'b1100, 1'b0);
    repeat (6) cycle(4'b1000, 1'b0);
    repeat (2) cycle(4'b0000, 1'b0);
    // reset in the middle of a burst, then restart from producer 0
    repeat (3) cycle(4'b1111, 1'b0);
    reset_mid(4'b1111);
    repeat (2) cycle(4'b1111, 1'b0);
    reset_n = 1'b1;
    in_rst  = 0;
    repeat (12) cycle(4'b1111, 1'b0);

    // randomized producers that hold req for a while and occasional full
    r = 4'b0000;
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (r[i]) r[i] = ($urandom_range(0, 7) != 0);
        else      r[i] = ($urandom_range(0, 2) == 0);
      end
      f = ($urandom_range(0, 3) == 0);
      cycle(r, f);
    end
    repeat (3) cycle(4'b0000, 1'b0);

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending records expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
